// File: rtl/bs_pkg.sv
// Shared definitions for the Monte-Carlo Black-Scholes accumulation core:
// command codes, FSM state encodings and the default fixed-point format.
package bs_pkg;

  localparam logic [3:0] CMD_RUN   = 4'd1;
  localparam logic [3:0] CMD_ACK   = 4'd2;
  localparam logic [3:0] CMD_ABORT = 4'd3;

  // Encodings double as the externally visible status code.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RUNNING  = 4'd1,
    ST_COMPLETE = 4'd2,
    ST_DRAIN    = 4'd3
  } state_e;

  localparam int BS_FW_DEFAULT = 12;

endpackage

// File: rtl/bs_payoff_sq_pipe.sv
// Payoff and square pipeline: input register, payoff stage, MULT_LAT-deep
// squarer (MULT_LAT >= 1) with the payoff delay-matched, and a valid shift chain.
module bs_payoff_sq_pipe #(
  parameter int DW       = 32,
  parameter int FW       = 12,
  parameter int MULT_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [DW-1:0]        i_data,
  input  logic [DW-1:0]        i_strike,
  input  logic                 i_put,
  output logic                 o_valid,
  output logic [DW-1:0]        o_payoff,
  output logic [2*DW-FW-1:0]   o_sq,
  output logic                 o_busy
);

  localparam int PW = 2 * DW;

  logic                r_in_v;
  logic [DW-1:0]       r_in_s;
  logic                r_p_v;
  logic [DW-1:0]       r_p_pay;
  logic [MULT_LAT-1:0] r_m_v;
  logic [PW-1:0]       r_m_prod [MULT_LAT];
  logic [DW-1:0]       r_m_pay  [MULT_LAT];

  logic [DW:0]         w_diff;
  logic [DW-1:0]       w_payoff;

  // NOTE: every always_comb output is assigned on every path so no latch is inferred.
  always_comb begin
    w_diff   = i_put ? ({1'b0, i_strike} - {1'b0, r_in_s})
                     : ({1'b0, r_in_s} - {1'b0, i_strike});
    w_payoff = w_diff[DW] ? '0 : w_diff[DW-1:0];
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_v <= 1'b0;
      r_p_v  <= 1'b0;
      r_m_v  <= '0;
    end else if (i_flush) begin
      r_in_v <= 1'b0;
      r_p_v  <= 1'b0;
      r_m_v  <= '0;
    end else begin
      r_in_v   <= i_valid;
      r_p_v    <= r_in_v;
      r_m_v[0] <= r_p_v;
      for (int k = 1; k < MULT_LAT; k++) begin
        r_m_v[k] <= r_m_v[k-1];
      end
    end
  end

  // NOTE: datapath registers carry no reset; only the valid chain qualifies them.
  always_ff @(posedge clk) begin
    r_in_s      <= i_data;
    r_p_pay     <= w_payoff;
    r_m_prod[0] <= PW'(r_p_pay) * PW'(r_p_pay);
    r_m_pay[0]  <= r_p_pay;
    for (int k = 1; k < MULT_LAT; k++) begin
      r_m_prod[k] <= r_m_prod[k-1];
      r_m_pay[k]  <= r_m_pay[k-1];
    end
  end

  assign o_valid  = r_m_v[MULT_LAT-1];
  assign o_payoff = r_m_pay[MULT_LAT-1];
  assign o_sq     = r_m_prod[MULT_LAT-1][PW-1:FW];
  assign o_busy   = r_in_v | r_p_v | (|r_m_v);

endmodule

// File: rtl/bs_mc_accum_core.sv
// Monte-Carlo payoff accumulator: RUN/ACK/ABORT command FSM, sample counters,
// and saturating sum / sum-of-squares accumulators fed by the payoff pipeline.
module bs_mc_accum_core
  import bs_pkg::*;
#(
  parameter int DW       = 32,
  parameter int FW       = BS_FW_DEFAULT,
  parameter int AW       = 64,
  parameter int MULT_LAT = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [3:0]    cmd,
  input  logic [31:0]   niter,
  input  logic [DW-1:0] constK,
  input  logic          put_mode,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [3:0]    status,
  output logic [AW-1:0] sum_dout,
  output logic [AW-1:0] pow_sum_dout,
  output logic          ovf
);

  localparam int SQW = 2 * DW - FW;
  localparam int MW  = (AW > SQW) ? AW : SQW;
  // One guard bit above the widest operand so any carry past AW is visible.
  localparam int EW  = ((MW > DW) ? MW : DW) + 1;

  state_e        r_state;
  logic [31:0]   r_niter;
  logic [31:0]   r_issued;
  logic [31:0]   r_retired;
  logic [DW-1:0] r_k;
  logic          r_put;
  logic          r_in_ready;
  logic [AW-1:0] r_sum;
  logic [AW-1:0] r_pow;
  logic          r_ovf;

  logic          w_active;
  logic          w_abort;
  logic          w_accept;
  logic          w_pipe_v;
  logic          w_pipe_busy;
  logic [DW-1:0] w_pay;
  logic [SQW-1:0] w_sq;
  logic [EW-1:0] w_sum_ext;
  logic [EW-1:0] w_pow_ext;
  logic          w_sum_sat;
  logic          w_pow_sat;
  logic [AW-1:0] w_sum_next;
  logic [AW-1:0] w_pow_next;

  assign w_active = (r_state == ST_RUNNING) || (r_state == ST_DRAIN);
  assign w_abort  = w_active && (cmd == CMD_ABORT);
  // A sample offered in the abort cycle is dropped together with the flush.
  assign w_accept = in_valid && r_in_ready && !w_abort;

  bs_payoff_sq_pipe #(
    .DW       (DW),
    .FW       (FW),
    .MULT_LAT (MULT_LAT)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (nreset),
    .i_flush  (w_abort),
    .i_valid  (w_accept),
    .i_data   (in_data),
    .i_strike (r_k),
    .i_put    (r_put),
    .o_valid  (w_pipe_v),
    .o_payoff (w_pay),
    .o_sq     (w_sq),
    .o_busy   (w_pipe_busy)
  );

  always_comb begin
    w_sum_ext  = EW'(r_sum) + EW'(w_pay);
    w_pow_ext  = EW'(r_pow) + EW'(w_sq);
    w_sum_sat  = |w_sum_ext[EW-1:AW];
    w_pow_sat  = |w_pow_ext[EW-1:AW];
    w_sum_next = w_sum_sat ? '1 : w_sum_ext[AW-1:0];
    w_pow_next = w_pow_sat ? '1 : w_pow_ext[AW-1:0];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_niter    <= '0;
      r_issued   <= '0;
      r_retired  <= '0;
      r_k        <= '0;
      r_put      <= 1'b0;
      r_in_ready <= 1'b0;
      r_sum      <= '0;
      r_pow      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      // Retirement is independent of issue so both can happen in one cycle.
      if (w_active && !w_abort && w_pipe_v) begin
        r_sum     <= w_sum_next;
        r_pow     <= w_pow_next;
        r_ovf     <= r_ovf | w_sum_sat | w_pow_sat;
        r_retired <= r_retired + 32'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (cmd == CMD_RUN) begin
            r_niter    <= niter;
            r_k        <= constK;
            r_put      <= put_mode;
            r_sum      <= '0;
            r_pow      <= '0;
            r_ovf      <= 1'b0;
            r_issued   <= '0;
            r_retired  <= '0;
            r_in_ready <= (niter != 32'd0);
            r_state    <= (niter == 32'd0) ? ST_COMPLETE : ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (w_abort) begin
            r_in_ready <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (w_accept) begin
            r_issued <= r_issued + 32'd1;
            if ((r_issued + 32'd1) == r_niter) begin
              r_in_ready <= 1'b0;
              r_state    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if ((r_retired == r_niter) && !w_pipe_busy) begin
            r_state <= ST_COMPLETE;
          end
        end
        ST_COMPLETE: begin
          if (cmd == CMD_ACK) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign status       = r_state;
  assign sum_dout     = r_sum;
  assign pow_sum_dout = r_pow;
  assign ovf          = r_ovf;

endmodule

// File: tb/tb_bs_mc_accum_core.sv
// Directed bench for bs_mc_accum_core: a default AW=64 instance and an AW=16
// instance share the stimulus; the narrow one exercises saturation.
module tb_bs_mc_accum_core;
  import bs_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 64;
  localparam int AWS = 16;
  localparam int ML  = 2;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [3:0]    cmd = 4'd0;
  logic [31:0]   niter = 32'd0;
  logic [DW-1:0] constK = '0;
  logic          put_mode = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready, in_ready_s;
  logic [3:0]    status, status_s;
  logic [AW-1:0] sum_dout, pow_sum_dout;
  logic [AWS-1:0] sum_dout_s, pow_sum_dout_s;
  logic          ovf, ovf_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bs_mc_accum_core #(.DW(DW), .FW(12), .AW(AW), .MULT_LAT(ML)) u_dut (
    .clk(clk), .nreset(nreset), .cmd(cmd), .niter(niter), .constK(constK),
    .put_mode(put_mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .status(status), .sum_dout(sum_dout),
    .pow_sum_dout(pow_sum_dout), .ovf(ovf)
  );

  bs_mc_accum_core #(.DW(DW), .FW(12), .AW(AWS), .MULT_LAT(ML)) u_dut_s (
    .clk(clk), .nreset(nreset), .cmd(cmd), .niter(niter), .constK(constK),
    .put_mode(put_mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_s), .status(status_s), .sum_dout(sum_dout_s),
    .pow_sum_dout(pow_sum_dout_s), .ovf(ovf_s)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] c);
    cmd = c;
    tick();
    cmd = 4'd0;
  endtask

  task automatic start_run(input logic [31:0] n, input logic [DW-1:0] k, input logic p);
    niter    = n;
    constK   = k;
    put_mode = p;
    send_cmd(CMD_RUN);
  endtask

  task automatic stream(input logic [DW-1:0] s, input int n);
    in_data  = s;
    in_valid = 1'b1;
    tick(n);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_status", status, 0);
    check("rst_sum", sum_dout, 0);
    check("rst_pow", pow_sum_dout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ready", in_ready, 0);
    nreset = 1'b1;
    tick();

    // Call: K=8.0, S=10.5 x4 -> payoff 2.5, square 6.25
    start_run(32'd4, 32'h8000, 1'b0);
    check("call_run_status", status, 1);
    check("call_run_ready", in_ready, 1);
    stream(32'hA800, 4);
    check("call_drain_status", status, 3);
    check("call_drain_ready", in_ready, 0);
    check("call_sum_before_first", sum_dout, 0);
    tick();
    check("call_sum_first", sum_dout, 64'h2800);
    check("call_pow_first", pow_sum_dout, 64'h6400);
    tick(3);
    check("call_last_retire_status", status, 3);
    check("call_sum", sum_dout, 64'hA000);
    check("call_pow", pow_sum_dout, 64'h19000);
    tick();
    check("call_complete", status, 2);
    tick(2);
    check("call_hold_sum", sum_dout, 64'hA000);
    start_run(32'd7, 32'h0, 1'b0);
    check("complete_ignores_run", status, 2);
    check("complete_ignores_run_sum", sum_dout, 64'hA000);
    send_cmd(CMD_ACK);
    check("ack_idle", status, 0);
    check("idle_hold_sum", sum_dout, 64'hA000);
    check("idle_hold_pow", pow_sum_dout, 64'h19000);

    // Put mode: S above strike gives zero, S=6.0 gives 2.0
    start_run(32'd4, 32'h8000, 1'b1);
    check("put_run_clears_sum", sum_dout, 0);
    stream(32'hA800, 4);
    tick(5);
    check("put_zero_status", status, 2);
    check("put_zero_sum", sum_dout, 0);
    check("put_zero_pow", pow_sum_dout, 0);
    send_cmd(CMD_ACK);
    start_run(32'd4, 32'h8000, 1'b1);
    stream(32'h6000, 4);
    tick(5);
    check("put_status", status, 2);
    check("put_sum", sum_dout, 64'h8000);
    check("put_pow", pow_sum_dout, 64'h10000);
    send_cmd(CMD_ACK);

    // niter = 0 completes immediately without ever accepting
    start_run(32'd0, 32'h8000, 1'b0);
    check("n0_status", status, 2);
    check("n0_ready", in_ready, 0);
    check("n0_sum", sum_dout, 0);
    check("n0_pow", pow_sum_dout, 0);
    tick(2);
    check("n0_ready_later", in_ready, 0);
    send_cmd(CMD_ACK);
    check("n0_ack_idle", status, 0);

    // Gapped input, niter=3, payoff 1.0; a 4th offered sample is refused
    start_run(32'd3, 32'h8000, 1'b0);
    in_data = 32'h9000;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
    end
    check("gap_drain_status", status, 3);
    check("gap_extra_not_ready", in_ready, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(3);
    check("gap_status", status, 2);
    check("gap_sum", sum_dout, 64'h3000);
    check("gap_pow", pow_sum_dout, 64'h3000);
    send_cmd(CMD_ACK);

    // Saturation on the AW=16 instance: payoff 7.0, square 49.0
    start_run(32'd4, 32'h8000, 1'b0);
    stream(32'hF000, 4);
    tick();
    check("sat_first_sum16", sum_dout_s, 64'h7000);
    check("sat_first_pow16", pow_sum_dout_s, 64'hFFFF);
    check("sat_first_ovf16", ovf_s, 1);
    check("sat_first_ovf64", ovf, 0);
    tick(4);
    check("sat_status16", status_s, 2);
    check("sat_sum16", sum_dout_s, 64'hFFFF);
    check("sat_pow16", pow_sum_dout_s, 64'hFFFF);
    check("sat_ovf16", ovf_s, 1);
    check("wide_sum64", sum_dout, 64'h1C000);
    check("wide_pow64", pow_sum_dout, 64'hC4000);
    check("wide_ovf64", ovf, 0);
    send_cmd(CMD_ACK);
    check("sat_ack_idle16", status_s, 0);
    check("sat_ovf_sticky16", ovf_s, 1);
    start_run(32'd0, 32'h8000, 1'b0);
    check("sat_run_clears_ovf16", ovf_s, 0);
    send_cmd(CMD_ACK);

    // ABORT with samples in flight; the next run must not see stale samples
    start_run(32'd8, 32'h8000, 1'b0);
    stream(32'h9000, 5);
    check("abort_pre_sum", sum_dout, 64'h1000);
    send_cmd(CMD_ABORT);
    check("abort_status", status, 0);
    check("abort_ready", in_ready, 0);
    check("abort_sum", sum_dout, 64'h1000);
    check("abort_pow", pow_sum_dout, 64'h1000);
    tick();
    check("abort_frozen_sum", sum_dout, 64'h1000);
    start_run(32'd1, 32'h8000, 1'b0);
    check("post_abort_run", status, 1);
    stream(32'hA000, 1);
    check("post_abort_drain", status, 3);
    tick(4);
    check("post_abort_sum_mid", sum_dout, 64'h2000);
    tick();
    check("post_abort_status", status, 2);
    check("post_abort_sum", sum_dout, 64'h2000);
    check("post_abort_pow", pow_sum_dout, 64'h4000);
    send_cmd(CMD_ACK);

    // Asynchronous reset mid-run
    start_run(32'd4, 32'h8000, 1'b0);
    stream(32'hF000, 4);
    tick();
    check("prerst_sum", sum_dout, 64'h7000);
    check("prerst_ovf16", ovf_s, 1);
    #2 nreset = 1'b0;
    #1;
    check("arst_status", status, 0);
    check("arst_sum", sum_dout, 0);
    check("arst_pow", pow_sum_dout, 0);
    check("arst_ready", in_ready, 0);
    check("arst_ovf16", ovf_s, 0);
    #2 nreset = 1'b1;
    tick(6);
    check("postrst_status", status, 0);
    check("postrst_sum", sum_dout, 0);
    check("postrst_pow", pow_sum_dout, 0);
    check("postrst_ovf16", ovf_s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
